// File: rtl/jtkcpu_busctl.sv
// jtkcpu_busctl: external bus controller for the JTKCPU core.
// Turns each byte-wide core access into a chip-select/dtack handshake on an
// 8- or 16-bit system bus, and gates the core clock enable so the core only
// advances once the current access has completed (or timed out).
module jtkcpu_busctl #(
    parameter int AW   = 24,   // byte address width
    parameter int DW   = 8,    // external data width, 8 or 16
    parameter int TOUT = 255   // dtack watchdog in clk cycles, 0 = disabled
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            halt,
    output logic            cpu_cen,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [7:0]      cpu_dout,
    input  logic            cpu_we,
    output logic [7:0]      cpu_din,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_dout,
    output logic [DW/8-1:0] bus_be,
    output logic            bus_we,
    output logic            bus_cs,
    input  logic [DW-1:0]   bus_din,
    input  logic            dtack,
    output logic            berr
);

    localparam int NL = DW / 8;
    // Counter is wide enough to hold TOUT; kept at one bit when disabled so
    // the register never collapses to zero width.
    localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (TOUT > 0) ? CW'(TOUT - 1) : '0;
    localparam logic [CW-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wdog_reg, wdog_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   dout_reg, dout_next;
    logic [NL-1:0]   be_reg, be_next;
    logic            we_reg, we_next;
    logic            cs_reg, cs_next;
    logic [7:0]      din_reg, din_next;
    logic            berr_reg, berr_next;

    logic [DW-1:0]   dout_rep;   // core byte copied onto every lane
    logic [NL-1:0]   be_start;   // lane enables for the access being started
    logic [7:0]      lane_data;  // read byte picked from the latched address

    genvar gi;

    // Write data goes out on every lane; the byte enables pick the real one.
    generate
        for (gi = 0; gi < NL; gi++) begin : g_rep
            assign dout_rep[gi*8 +: 8] = cpu_dout;
        end
    endgenerate

    // Big-endian lane mapping: even byte addresses live on the upper lane.
    generate
        if (DW == 16) begin : g_w16
            assign be_start  = cpu_addr[0] ? 2'b01 : 2'b10;
            assign lane_data = addr_reg[0] ? bus_din[7:0] : bus_din[15:8];
        end else begin : g_w8
            assign be_start  = 1'b1;
            assign lane_data = bus_din[7:0];
        end
    endgenerate

    // State and registered bus outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            wdog_reg  <= '0;
            addr_reg  <= '0;
            dout_reg  <= '0;
            be_reg    <= '0;
            we_reg    <= 1'b0;
            cs_reg    <= 1'b0;
            din_reg   <= 8'hFF;
            berr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wdog_reg  <= wdog_next;
            addr_reg  <= addr_next;
            dout_reg  <= dout_next;
            be_reg    <= be_next;
            we_reg    <= we_next;
            cs_reg    <= cs_next;
            din_reg   <= din_next;
            berr_reg  <= berr_next;
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT/DONE handshake.
    always_comb begin
        state_next = state_reg;
        wdog_next  = wdog_reg;
        addr_next  = addr_reg;
        dout_next  = dout_reg;
        be_next    = be_reg;
        we_next    = we_reg;
        cs_next    = cs_reg;
        din_next   = din_reg;
        berr_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // halt only matters here: it keeps new accesses from starting
                if (cen && !halt) begin
                    addr_next  = cpu_addr;
                    dout_next  = dout_rep;
                    we_next    = cpu_we;
                    be_next    = be_start;
                    cs_next    = 1'b1;
                    wdog_next  = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dtack) begin
                    // dtack beats a simultaneous timeout
                    if (!we_reg) begin
                        din_next = lane_data;
                    end
                    cs_next    = 1'b0;
                    we_next    = 1'b0;
                    state_next = DONE;
                end else if ((TOUT != 0) && (wdog_reg == WD_LAST)) begin
                    berr_next  = 1'b1;
                    din_next   = 8'hFF;
                    cs_next    = 1'b0;
                    we_next    = 1'b0;
                    state_next = DONE;
                end else if (wdog_reg != WD_MAX) begin
                    wdog_next = wdog_reg + CW'(1);
                end
            end
            DONE: begin
                if (cen) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_cen  = cen & (state_reg == DONE);
    assign cpu_din  = din_reg;
    assign bus_addr = addr_reg;
    assign bus_dout = dout_reg;
    assign bus_be   = be_reg;
    assign bus_we   = we_reg;
    assign bus_cs   = cs_reg;
    assign berr     = berr_reg;

endmodule

// File: tb/tb_jtkcpu_busctl.sv
// Bench for jtkcpu_busctl: an 8-bit instance with an 8-clk watchdog (A) and a
// 16-bit instance with the watchdog disabled (B) run the same core accesses.
// Expected completions are queued when an access is launched and compared
// when the matching cpu_cen pulse appears.
module tb_jtkcpu_busctl;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        halt;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;

    logic        cpu_cen_a, cpu_cen_b;
    logic [7:0]  cpu_din_a, cpu_din_b;
    logic [23:0] bus_addr_a, bus_addr_b;
    logic [7:0]  bus_dout_a;
    logic [15:0] bus_dout_b;
    logic [0:0]  bus_be_a;
    logic [1:0]  bus_be_b;
    logic        bus_we_a, bus_we_b;
    logic        bus_cs_a, bus_cs_b;
    logic [7:0]  bus_din_a;
    logic [15:0] bus_din_b;
    logic        dtack_a, dtack_b;
    logic        berr_a, berr_b;

    jtkcpu_busctl #(.AW(24), .DW(8), .TOUT(8)) dut_a (
        .clk(clk), .rst(rst), .cen(cen), .halt(halt), .cpu_cen(cpu_cen_a),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din_a), .bus_addr(bus_addr_a), .bus_dout(bus_dout_a),
        .bus_be(bus_be_a), .bus_we(bus_we_a), .bus_cs(bus_cs_a),
        .bus_din(bus_din_a), .dtack(dtack_a), .berr(berr_a)
    );

    jtkcpu_busctl #(.AW(24), .DW(16), .TOUT(0)) dut_b (
        .clk(clk), .rst(rst), .cen(cen), .halt(halt), .cpu_cen(cpu_cen_b),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din_b), .bus_addr(bus_addr_b), .bus_dout(bus_dout_b),
        .bus_be(bus_be_b), .bus_we(bus_we_b), .bus_cs(bus_cs_b),
        .bus_din(bus_din_b), .dtack(dtack_b), .berr(berr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        int         berr;
        int         cs;
        int         we;
        int         lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cs_cnt[2];
    int we_cnt[2];
    int berr_cnt[2];
    int berr_total[2];
    int rise_cyc[2];
    int berr_cyc[2];
    int done_cnt[2];
    logic cs_prev[2];
    logic [7:0] mdl_a, mdl_b;   // model of each cpu_din register

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Per-instance observer, sampled mid-cycle.
    task automatic mon(input int d, input logic cs, input logic we, input logic be_r,
                       input logic cc, input logic [7:0] din);
        exp_t  e;
        string tg;
        tg = (d == 0) ? "A" : "B";
        if (be_r) berr_total[d]++;
        if (rst) begin
            cs_cnt[d]   = 0;
            we_cnt[d]   = 0;
            berr_cnt[d] = 0;
            cs_prev[d]  = cs;
        end else begin
            if (cs && !cs_prev[d]) rise_cyc[d] = cyc;
            cs_prev[d] = cs;
            if (cs) cs_cnt[d]++;
            if (cs && we) we_cnt[d]++;
            if (be_r) begin
                berr_cnt[d]++;
                berr_cyc[d] = cyc;
            end
            if (cc) begin
                if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                    check({tg, "_spurious_cen"}, 32'(cc), 32'd0);
                end else begin
                    if (d == 0) e = q_a.pop_front();
                    else        e = q_b.pop_front();
                    $display("txn dut=%s din=%02h berr=%0d cs_clks=%0d we_clks=%0d lat=%0d",
                             tg, din, berr_cnt[d], cs_cnt[d], we_cnt[d], cyc - rise_cyc[d]);
                    check({tg, "_cpu_din"}, 32'(din), 32'(e.din));
                    check({tg, "_berr_pulses"}, berr_cnt[d], e.berr);
                    check({tg, "_cs_clks"}, cs_cnt[d], e.cs);
                    check({tg, "_we_clks"}, we_cnt[d], e.we);
                    check({tg, "_cen_latency"}, cyc - rise_cyc[d], e.lat);
                    if (e.berr != 0) check({tg, "_berr_delay"}, berr_cyc[d] - rise_cyc[d], 8);
                    cs_cnt[d]   = 0;
                    we_cnt[d]   = 0;
                    berr_cnt[d] = 0;
                    done_cnt[d]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, bus_cs_a, bus_we_a, berr_a, cpu_cen_a, cpu_din_a);
        mon(1, bus_cs_b, bus_we_b, berr_b, cpu_cen_b, cpu_din_b);
    end

    task automatic push_read(input logic [7:0] dina, input logic [15:0] dinb,
                             input logic a0, input int lat);
        exp_t e;
        mdl_a = dina;
        mdl_b = a0 ? dinb[7:0] : dinb[15:8];
        e.din = mdl_a; e.berr = 0; e.cs = 1; e.we = 0; e.lat = lat;
        q_a.push_back(e);
        e.din = mdl_b;
        q_b.push_back(e);
    endtask

    task automatic wait_done(input int na, input int nb, input string name);
        for (int i = 0; i < 80 && !(done_cnt[0] >= na && done_cnt[1] >= nb); i++) tick;
        check({name, "_doneA"}, done_cnt[0], na);
        check({name, "_doneB"}, done_cnt[1], nb);
    endtask

    // One access on both instances, launched with cen every clk; halt is
    // raised as soon as the access starts. dA/dB = dtack-low clks in WAIT.
    task automatic run_access(input string name, input logic [23:0] addr,
                              input logic [7:0] wd, input logic we,
                              input logic [7:0] dina, input logic [15:0] dinb,
                              input int da, input int db);
        exp_t e;
        bit   toa;
        int   na, nb, k;
        toa = (da >= 8);
        e.cs   = toa ? 8 : da + 1;
        e.berr = toa ? 1 : 0;
        e.we   = we ? e.cs : 0;
        e.lat  = e.cs;
        if (toa) mdl_a = 8'hFF;
        else if (!we) mdl_a = dina;
        e.din = mdl_a;
        q_a.push_back(e);
        e.cs   = db + 1;
        e.berr = 0;
        e.we   = we ? e.cs : 0;
        e.lat  = e.cs;
        if (!we) mdl_b = addr[0] ? dinb[7:0] : dinb[15:8];
        e.din = mdl_b;
        q_b.push_back(e);
        na = done_cnt[0] + 1;
        nb = done_cnt[1] + 1;

        cpu_addr  = addr;
        cpu_dout  = wd;
        cpu_we    = we;
        bus_din_a = dina;
        bus_din_b = dinb;
        dtack_a   = (da == 0);
        dtack_b   = (db == 0);
        halt      = 1'b0;
        tick;
        halt = 1'b1;
        check({name, "_csA"}, 32'(bus_cs_a), 32'd1);
        check({name, "_csB"}, 32'(bus_cs_b), 32'd1);
        check({name, "_addrA"}, 32'(bus_addr_a), 32'(addr));
        check({name, "_addrB"}, 32'(bus_addr_b), 32'(addr));
        check({name, "_beA"}, 32'(bus_be_a), 32'd1);
        check({name, "_beB"}, 32'(bus_be_b), addr[0] ? 32'd1 : 32'd2);
        check({name, "_weA"}, 32'(bus_we_a), 32'(we));
        check({name, "_weB"}, 32'(bus_we_b), 32'(we));
        if (we) begin
            check({name, "_doutA"}, 32'(bus_dout_a), 32'(wd));
            check({name, "_doutB"}, 32'(bus_dout_b), 32'({wd, wd}));
        end
        k = 0;
        while (!(done_cnt[0] >= na && done_cnt[1] >= nb) && k < 80) begin
            tick;
            k++;
            dtack_a = (k >= da);
            dtack_b = (k >= db);
        end
        check({name, "_doneA"}, done_cnt[0], na);
        check({name, "_doneB"}, done_cnt[1], nb);
        dtack_a = 1'b0;
        dtack_b = 1'b0;
        tick;
        check({name, "_halted_csA"}, 32'(bus_cs_a), 32'd0);
        check({name, "_halted_csB"}, 32'(bus_cs_b), 32'd0);
    endtask

    int d0, d1, bt0, bt1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cs_cnt[i] = 0; we_cnt[i] = 0; berr_cnt[i] = 0; berr_total[i] = 0;
            rise_cyc[i] = 0; berr_cyc[i] = 0; done_cnt[i] = 0; cs_prev[i] = 1'b0;
        end
        mdl_a = 8'hFF;
        mdl_b = 8'hFF;
        rst = 1'b1; cen = 1'b1; halt = 1'b1;
        cpu_addr = 24'h0; cpu_dout = 8'h0; cpu_we = 1'b0;
        bus_din_a = 8'h0; bus_din_b = 16'h0; dtack_a = 1'b0; dtack_b = 1'b0;
        tick; tick; tick;

        // reset values
        check("rst_csA", 32'(bus_cs_a), 32'd0);
        check("rst_weA", 32'(bus_we_a), 32'd0);
        check("rst_beA", 32'(bus_be_a), 32'd0);
        check("rst_beB", 32'(bus_be_b), 32'd0);
        check("rst_addrA", 32'(bus_addr_a), 32'd0);
        check("rst_doutB", 32'(bus_dout_b), 32'd0);
        check("rst_dinA", 32'(cpu_din_a), 32'hFF);
        check("rst_dinB", 32'(cpu_din_b), 32'hFF);
        check("rst_cenA", 32'(cpu_cen_a), 32'd0);
        check("rst_berrA", 32'(berr_a), 32'd0);
        rst = 1'b0;
        tick;
        check("halt_idle_csA", 32'(bus_cs_a), 32'd0);

        // minimum-latency reads, dtack tied high; even then odd address
        run_access("rd_even", 24'h001234, 8'h00, 1'b0, 8'hA5, 16'h1234, 0, 0);
        run_access("rd_odd",  24'h000101, 8'h00, 1'b0, 8'h3C, 16'h1234, 0, 0);
        // write with dtack held off for 4 clks
        run_access("wr_dly",  24'h000201, 8'h5A, 1'b1, 8'hEE, 16'hEEEE, 4, 4);
        // A times out; B has no watchdog and waits 20 clks
        run_access("tout",    24'h000300, 8'h00, 1'b0, 8'h77, 16'hBEEF, 8, 20);
        // dtack arrives on the timeout clk: normal completion on A
        run_access("race",    24'h000301, 8'h00, 1'b0, 8'h66, 16'hC3D2, 7, 7);

        // halt release waits for cen; DONE waits for cen before pulsing cpu_cen
        push_read(8'h9A, 16'h5678, 1'b0, 2);
        cpu_addr = 24'h000400; cpu_we = 1'b0;
        bus_din_a = 8'h9A; bus_din_b = 16'h5678;
        dtack_a = 1'b1; dtack_b = 1'b1;
        cen = 1'b0; halt = 1'b0;
        tick; tick;
        check("nocen_csA", 32'(bus_cs_a), 32'd0);
        check("nocen_csB", 32'(bus_cs_b), 32'd0);
        cen = 1'b1;
        tick;
        check("cen_start_csA", 32'(bus_cs_a), 32'd1);
        check("cen_start_csB", 32'(bus_cs_b), 32'd1);
        halt = 1'b1; cen = 1'b0;
        tick;
        check("gate_done_cenA", 32'(cpu_cen_a), 32'd0);
        check("gate_done_csA", 32'(bus_cs_a), 32'd0);
        tick;
        check("gate_hold_cenA", 32'(cpu_cen_a), 32'd0);
        check("gate_hold_cenB", 32'(cpu_cen_b), 32'd0);
        cen = 1'b1;
        #1;
        check("gate_pulse_cenA", 32'(cpu_cen_a), 32'd1);
        check("gate_pulse_cenB", 32'(cpu_cen_b), 32'd1);
        wait_done(done_cnt[0] + 1, done_cnt[1] + 1, "gate");
        tick;

        // back-to-back accesses: restart no earlier than the following cen
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        push_read(8'h11, 16'h2233, 1'b0, 1);
        push_read(8'h11, 16'h2233, 1'b0, 1);
        cpu_addr = 24'h000500; bus_din_a = 8'h11; bus_din_b = 16'h2233;
        dtack_a = 1'b1; dtack_b = 1'b1; halt = 1'b0;
        tick;
        check("b2b_cs1A", 32'(bus_cs_a), 32'd1);
        tick;
        check("b2b_doneA", 32'(bus_cs_a), 32'd0);
        check("b2b_done_cenA", 32'(cpu_cen_a), 32'd1);
        tick;
        check("b2b_idle_csA", 32'(bus_cs_a), 32'd0);
        check("b2b_idle_cenA", 32'(cpu_cen_a), 32'd0);
        tick;
        halt = 1'b1;
        check("b2b_cs2A", 32'(bus_cs_a), 32'd1);
        check("b2b_cs2B", 32'(bus_cs_b), 32'd1);
        wait_done(d0 + 2, d1 + 2, "b2b");
        dtack_a = 1'b0; dtack_b = 1'b0;
        tick;

        // reset while waiting for dtack: access abandoned silently
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        bt0 = berr_total[0];
        bt1 = berr_total[1];
        cpu_addr = 24'h000600; bus_din_a = 8'h42; bus_din_b = 16'h4242;
        halt = 1'b0;
        tick;
        halt = 1'b1;
        check("rstw_csA", 32'(bus_cs_a), 32'd1);
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstw_csA_cleared", 32'(bus_cs_a), 32'd0);
        check("rstw_csB_cleared", 32'(bus_cs_b), 32'd0);
        check("rstw_addrA", 32'(bus_addr_a), 32'd0);
        check("rstw_dinA", 32'(cpu_din_a), 32'hFF);
        check("rstw_dinB", 32'(cpu_din_b), 32'hFF);
        dtack_a = 1'b1; dtack_b = 1'b1;
        for (int i = 0; i < 12; i++) tick;
        check("rstw_no_cenA", done_cnt[0], d0);
        check("rstw_no_cenB", done_cnt[1], d1);
        check("rstw_no_berrA", berr_total[0], bt0);
        check("rstw_no_berrB", berr_total[1], bt1);
        check("rstw_idle_csA", 32'(bus_cs_a), 32'd0);

        check("queue_emptyA", q_a.size(), 0);
        check("queue_emptyB", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtkcpu_busctl.md
# jtkcpu_busctl

Parametrised external bus controller for the JTKCPU core. It sits between the core's byte-wide memory port and the system bus, turning each core access into a chip-select/dtack handshake. It supports 8- or 16-bit data buses, arbitrary address width, halt, and a wait-state watchdog. It produces the gated clock enable that advances the core only when the current access has completed, so slow or shared memories stall the core cleanly.

## Interface

Parameters:
- AW, 24, address width in bits (byte address)
- DW, 8, external data width; legal values 8 or 16
- TOUT, 255, dtack watchdog in clk cycles; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  base clock enable
- halt  in  1  blocks start of new accesses
- cpu_cen  out  1  gated enable to the core; one pulse per completed access
- cpu_addr  in  AW  core byte address
- cpu_dout  in  8  core write data
- cpu_we  in  1  core write request
- cpu_din  out  8  read data to the core (registered)
- bus_addr  out  AW  latched byte address
- bus_dout  out  DW  write data; the byte is replicated on every lane
- bus_be  out  DW/8  byte-lane enables
- bus_we  out  1  write strobe, valid while bus_cs=1
- bus_cs  out  1  access in progress
- bus_din  in  DW  external read data
- dtack  in  1  access complete, sampled every clk
- berr  out  1  one-clk pulse on watchdog timeout

## Operation

- FSM with three states: IDLE, WAIT, DONE.
- IDLE, on cen=1 and halt=0:
  - latch cpu_addr, cpu_dout and cpu_we into bus_addr, bus_dout and bus_we
  - compute bus_be
  - set bus_cs=1
  - clear the watchdog counter
  - go to WAIT
- IDLE with halt=1: stay in IDLE; cpu_cen stays 0.
- WAIT, dtack=1:
  - on a read, capture the selected lane into cpu_din; on a write, cpu_din holds its value
  - clear bus_cs and bus_we
  - go to DONE
- WAIT, dtack=0: increment the watchdog counter.
  - If TOUT≠0 and the counter reaches TOUT-1 while dtack is still 0: berr=1 for one clk, cpu_din=8'hFF, bus_cs=0, go to DONE.
  - dtack arriving on the same clk as the timeout wins: normal completion, no berr.
- DONE, on cen=1: cpu_cen=1 for exactly that clk, go to IDLE. The next access can start no earlier than the following cen.
- halt has no effect in WAIT or DONE. An access in flight always completes.
- Lane rules:
  - DW=8: bus_be=1'b1; cpu_din=bus_din.
  - DW=16 (big-endian): addr[0]=0 selects the upper byte, bus_be=2'b10, cpu_din=bus_din[15:8]; addr[0]=1 gives bus_be=2'b01, cpu_din=bus_din[7:0].
  - bus_addr always carries the full byte address.
- The watchdog counter is $clog2(TOUT+1) bits wide and saturates; it never wraps.

## Timing

- Reset values (reset can hit any state; the in-flight access is abandoned and no cpu_cen or berr is issued):
  - state IDLE
  - bus_cs=0, bus_we=0, bus_be=0
  - bus_addr=0, bus_dout=0
  - cpu_din=8'hFF
  - cpu_cen=0, berr=0
- cpu_cen is combinational: cen & (state==DONE). All other outputs are registered.
- bus_cs rises one clk after the starting cen. With dtack already high, bus_cs is held for exactly one clk.
- Minimum access: start on cen k, complete on the next cen where DONE has been reached. With cen every clk: start at clk n, bus_cs=1 during n+1, DONE at n+2, cpu_cen=1 at n+2. That gives one core step per 3 clks.
- Each extra dtack-low clk in WAIT adds one clk of latency.
- dtack is ignored outside WAIT.
- A timeout asserts berr on the clk the FSM enters DONE.

## Test plan

- DW=8, cen every clk, dtack tied high, read from 0x001234 with bus_din=8'hA5: bus_cs high for 1 clk, cpu_cen pulse 2 clks after start, cpu_din=8'hA5.
- DW=16 read at odd address 0x000101 with bus_din=16'h1234: bus_be=2'b01, cpu_din=8'h34. At even address 0x000100: bus_be=2'b10, cpu_din=8'h12.
- Write 8'h5A with dtack delayed 4 clks: bus_we=1 and bus_cs=1 for 5 clks, bus_dout=8'h5A (16'h5A5A for DW=16), single cpu_cen afterwards.
- TOUT=8, dtack held low: berr pulses once, 8 clks after bus_cs rises. cpu_din=8'hFF, one cpu_cen. Repeat with dtack rising on the timeout clk: no berr, read data captured.
- halt=1 asserted while in WAIT: the current access completes with one cpu_cen, then no bus_cs while halt=1. Releasing halt starts the next access on the next cen.
- rst pulsed in WAIT: the next clk shows bus_cs=0 and state IDLE. No cpu_cen or berr is generated for the abandoned access.
